// File: rtl/anc_fir_mac.sv
// Purpose     : 64-tap adaptive FIR stage for the ANC chain; one shared multiplier, circular sample history.
// Latency     : done_out pulses 65 cycles after the accepting edge; data_out held until the next result.
// Backpressure: none; ready_in while busy drops the sample and pulses overrun_out.
// Build option: define FIR_SATURATE_EN to clamp data_out to the DATA_W signed range (default wraps).
module anc_fir_mac #(
  parameter int TAPS       = 64,
  parameter int DATA_W     = 16,
  parameter int COEFF_W    = 10,
  parameter int COEFF_FRAC = 9,
  parameter int ACC_W      = 32
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           ready_in,
  input  logic signed [DATA_W-1:0]       sample_in,
  input  logic [TAPS-1:0][COEFF_W-1:0]   coeffs_in,
  output logic [TAPS-1:0][DATA_W-1:0]    sample_buf_out,
  output logic [$clog2(TAPS)-1:0]        offset_out,
  output logic signed [DATA_W-1:0]       data_out,
  output logic                           done_out,
  output logic                           busy_out,
  output logic                           overrun_out
);

  localparam int PTR_W  = $clog2(TAPS);
  localparam int PROD_W = COEFF_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic                           accept;
  logic [PTR_W-1:0]               wr_ptr_q;
  logic [PTR_W-1:0]               k_q;
  logic [PTR_W-1:0]               rd_idx;
  logic signed [ACC_W-1:0]        acc_q;
  logic [TAPS-1:0][COEFF_W-1:0]   coef_q;
  logic signed [COEFF_W-1:0]      tap_coef;
  logic signed [DATA_W-1:0]       tap_sample;
  logic signed [PROD_W-1:0]       prod;
  logic signed [ACC_W-1:0]        shifted;
  logic signed [DATA_W-1:0]       result;

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a sample is only taken in IDLE, so the OUT edge drops it.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ready_in) begin
          accept  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC:   if (k_q == PTR_W'(TAPS - 1)) state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One tap per cycle: newest sample pairs with coef[0], walking backwards through history.
  always_comb begin
    rd_idx     = offset_out - k_q;
    tap_coef   = $signed(coef_q[k_q]);
    tap_sample = $signed(sample_buf_out[rd_idx]);
    prod       = PROD_W'(tap_coef) * PROD_W'(tap_sample);
  end

  // Scale back to sample units; floor rounding via arithmetic shift.
  always_comb begin
    shifted = acc_q >>> COEFF_FRAC;
`ifdef FIR_SATURATE_EN
    if (shifted > $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}}))
      result = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}}))
      result = {1'b1, {(DATA_W-1){1'b0}}};
    else
      result = shifted[DATA_W-1:0];
`else
    result = shifted[DATA_W-1:0];
`endif
  end

  // History buffer, pointers and coefficient snapshot only move on acceptance,
  // keeping the LMS view stable between results.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sample_buf_out <= '0;
      wr_ptr_q       <= '0;
      offset_out     <= '0;
      coef_q         <= '0;
    end else if (accept) begin
      sample_buf_out[wr_ptr_q] <= sample_in;
      offset_out               <= wr_ptr_q;
      wr_ptr_q                 <= wr_ptr_q + PTR_W'(1);
      coef_q                   <= coeffs_in;
    end
  end

  // Multiply-accumulate sequencing.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_q <= '0;
      k_q   <= '0;
    end else if (accept) begin
      acc_q <= '0;
      k_q   <= '0;
    end else if (state_q == S_MAC) begin
      acc_q <= acc_q + ACC_W'(prod);
      k_q   <= k_q + PTR_W'(1);
    end
  end

  // Registered result and status strobes.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_out    <= '0;
      done_out    <= 1'b0;
      busy_out    <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      if (state_q == S_OUT) data_out <= result;
      done_out    <= (state_q == S_OUT);
      busy_out    <= (state_d != S_IDLE);
      overrun_out <= ready_in && (state_q != S_IDLE);
    end
  end

endmodule

// File: tb/tb_anc_fir_mac.sv
module tb_anc_fir_mac;

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic                  ready_in;
  logic signed [15:0]    sample_in;
  logic [63:0][9:0]      coeffs;
  logic [63:0][15:0]     sample_buf_out;
  logic [5:0]            offset_out;
  logic signed [15:0]    data_out;
  logic                  done_out;
  logic                  busy_out;
  logic                  overrun_out;

  int errors = 0;
  int checks = 0;

  // reference model state
  int mbuf [64];
  int snap [64];
  int wr;
  int moff;

`ifdef FIR_SATURATE_EN
  localparam int SAT_EXP = 32767;
`else
  localparam int SAT_EXP = -4160;
`endif

  anc_fir_mac dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .ready_in       (ready_in),
    .sample_in      (sample_in),
    .coeffs_in      (coeffs),
    .sample_buf_out (sample_buf_out),
    .offset_out     (offset_out),
    .data_out       (data_out),
    .done_out       (done_out),
    .busy_out       (busy_out),
    .overrun_out    (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_buf(input string tag);
    logic [63:0][15:0] exp_buf;
    for (int i = 0; i < 64; i++) exp_buf[i] = 16'(mbuf[i]);
    checks++;
    assert (sample_buf_out === exp_buf) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, sample_buf_out, exp_buf);
    end
  endtask

  function automatic int model_out();
    longint acc = 0;
    longint sh;
    for (int k = 0; k < 64; k++)
      acc += longint'(snap[k]) * longint'(mbuf[(moff - k) & 63]);
    sh = acc >>> 9;
`ifdef FIR_SATURATE_EN
    if (sh > 32767)  sh = 32767;
    if (sh < -32768) sh = -32768;
`else
    sh = sh & 64'hFFFF;
    if (sh >= 32768) sh -= 65536;
`endif
    return int'(sh);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) mbuf[i] = 0;
    wr = 0;
    moff = 0;
  endfunction

  task automatic randomize_coeffs();
    for (int i = 0; i < 64; i++) coeffs[i] = 10'($urandom);
  endtask

  // Present one sample, optionally disturb coeffs / fire an extra ready_in
  // (at an edge offset from acceptance), then wait for and check the result.
  task automatic do_sample(input logic signed [15:0] s, input int perturb_at, input int overrun_at);
    int m;
    int exp_y;
    @(negedge clk_in);
    ready_in  = 1'b1;
    sample_in = s;
    @(negedge clk_in);
    ready_in  = 1'b0;
    sample_in = '0;
    mbuf[wr] = s;
    moff     = wr;
    wr       = (wr + 1) % 64;
    for (int k = 0; k < 64; k++) snap[k] = $signed(coeffs[k]);
    exp_y = model_out();
    m = 0;
    while (!done_out && m < 200) begin
      if (m == perturb_at) randomize_coeffs();
      if (m == overrun_at - 1) begin
        ready_in  = 1'b1;
        sample_in = 16'sd7;
      end
      @(negedge clk_in);
      m++;
      ready_in  = 1'b0;
      sample_in = '0;
      if (m == 1) check("busy_inflight", busy_out, 1);
      if (m == overrun_at) check("overrun_pulse", overrun_out, 1);
      if (m == overrun_at + 1) check("overrun_clear", overrun_out, 0);
    end
    check("latency", m, 65);
    check("data_out", data_out, exp_y);
    check("offset_out", offset_out, moff);
    check("busy_done", busy_out, 0);
    check_buf("sample_buf");
    @(negedge clk_in);
    check("done_single", done_out, 0);
  endtask

  initial begin
    int cnt;
    logic [63:0][9:0] keep;
    rst_in    = 1'b1;
    ready_in  = 1'b0;
    sample_in = '0;
    coeffs    = '0;
    model_reset();
    repeat (3) @(negedge clk_in);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_data", data_out, 0);
    check("rst_offset", offset_out, 0);
    check("rst_overrun", overrun_out, 0);
    check_buf("rst_buf");
    rst_in = 1'b0;
    @(negedge clk_in);

    // impulse response through tap 3; last sample also has coeffs disturbed mid-flight
    coeffs[3] = 10'd256;
    do_sample(16'sd1000, -1, -1); check("t1_y0", data_out, 0);
    do_sample(16'sd0,    -1, -1); check("t1_y1", data_out, 0);
    do_sample(16'sd0,    -1, -1); check("t1_y2", data_out, 0);
    keep = coeffs;
    do_sample(16'sd0,     5, -1); check("t1_y3", data_out, 500);
    coeffs = keep;

    // asynchronous reset during a computation
    @(negedge clk_in); ready_in = 1'b1; sample_in = 16'sd1234;
    @(negedge clk_in); ready_in = 1'b0; sample_in = '0;
    repeat (30) @(negedge clk_in);
    check("t5_busy_pre", busy_out, 1);
    rst_in = 1'b1;
    #1;
    check("t5_busy", busy_out, 0);
    check("t5_data", data_out, 0);
    check("t5_offset", offset_out, 0);
    model_reset();
    check_buf("t5_buf");
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk_in);
      if (done_out) cnt++;
    end
    check("t5_no_done", cnt, 0);
    check("t5_idle", busy_out, 0);

    // pointer wrap over 65 samples, random weights
    randomize_coeffs();
    for (int i = 0; i < 65; i++) begin
      do_sample(16'(i + 1), -1, -1);
      check("t2_offset", offset_out, i % 64);
    end
    check("t2_buf0", sample_buf_out[0], 65);
    check("t2_buf1", sample_buf_out[1], 2);

    // overrun mid-computation: sample 7 dropped, result unaffected
    do_sample(16'($urandom), -1, 10);
    check("t3_offset", offset_out, 1);
    do_sample(16'($urandom), -1, -1);
    check("t3_wr_next", offset_out, 2);

    // full-scale accumulation
    for (int i = 0; i < 64; i++) coeffs[i] = 10'd511;
    for (int i = 0; i < 64; i++) do_sample(16'sd32767, -1, -1);
    check("t4_sat", data_out, SAT_EXP);

    // random samples and weights
    for (int i = 0; i < 8; i++) begin
      randomize_coeffs();
      do_sample(16'($urandom), (i % 2 == 0) ? 20 : -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
